lane_fifo_bank_4x8: RTL and testbench

Four-lane elastic buffer directly downstream of the 1x4 byte demux: absorbs bytes the demux emits on each of its four 8-bit lanes and holds them until the per-lane consumer (lane serializer) pops them. Each lane has an independent FIFO with full/empty/almost-full flags, so the demux can run while a lane consumer stalls. Optional sticky overflow/underflow error reporting is available for bring-up.

---
 rtl/lane_fifo_bank_4x8_pkg.sv | 17 +
 rtl/lane_fifo_8.sv | 60 ++++++
 rtl/lane_fifo_bank_4x8.sv | 76 +++++++
 tb/tb_lane_fifo_bank_4x8.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/lane_fifo_bank_4x8_pkg.sv
// lane_fifo_bank_4x8_pkg: shared lane/byte widths, default FIFO geometry and per-lane status bundle
package lane_fifo_bank_4x8_pkg;
  localparam int LANES = 4;
  localparam int BYTE_W = 8;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_AF_LEVEL = 3;
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic err_ovf;
    logic err_udf;
  } lane_flags_t;
  function automatic int ptr_w(int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/lane_fifo_8.sv
// lane_fifo_8: single-lane byte FIFO with registered pop output and flags; LANE_ERR_EN adds sticky ovf/udf errors
module lane_fifo_8
  import lane_fifo_bank_4x8_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              pop,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output lane_flags_t       flags
);
  localparam int PW = ptr_w(DEPTH);
  localparam int CW = PW + 1;
  logic [BYTE_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic pop_acc, push_acc, err_ovf, err_udf;
  assign pop_acc = pop && (count != '0);
  assign push_acc = valid_in && ((count != CW'(DEPTH)) || pop_acc);
  // storage carries no reset; stale contents are unreachable once pointers clear
  always_ff @(posedge clk)
    if (push_acc) mem[wr_ptr] <= data_in;
  // pointers, occupancy and the registered pop output
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      data_out <= '0;
      valid_out <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + PW'(1);
      if (pop_acc) begin
        rd_ptr <= rd_ptr + PW'(1);
        data_out <= mem[rd_ptr];
      end
      valid_out <= pop_acc;
      count <= count + CW'(push_acc) - CW'(pop_acc);
    end
`ifdef LANE_ERR_EN
  // sticky errors: dropped push sets ovf, pop on empty sets udf
  always_ff @(posedge clk or negedge reset_L)
    if (!reset_L) begin
      err_ovf <= 1'b0;
      err_udf <= 1'b0;
    end else begin
      if (valid_in && !push_acc) err_ovf <= 1'b1;
      if (pop && !pop_acc) err_udf <= 1'b1;
    end
`else
  assign err_ovf = 1'b0;
  assign err_udf = 1'b0;
`endif
  assign flags = '{count == CW'(DEPTH), count == '0, count >= CW'(AF_LEVEL), err_ovf, err_udf};
endmodule

// File: rtl/lane_fifo_bank_4x8.sv
// lane_fifo_bank_4x8: four independent byte FIFOs behind the 1x4 demux; LANE_ERR_EN enables sticky error outputs
module lane_fifo_bank_4x8
  import lane_fifo_bank_4x8_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AF_LEVEL = DEF_AF_LEVEL
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [BYTE_W-1:0] data_in0,
  input  logic [BYTE_W-1:0] data_in1,
  input  logic [BYTE_W-1:0] data_in2,
  input  logic [BYTE_W-1:0] data_in3,
  input  logic              valid_in0,
  input  logic              valid_in1,
  input  logic              valid_in2,
  input  logic              valid_in3,
  input  logic              pop0,
  input  logic              pop1,
  input  logic              pop2,
  input  logic              pop3,
  output logic [BYTE_W-1:0] data_out0,
  output logic [BYTE_W-1:0] data_out1,
  output logic [BYTE_W-1:0] data_out2,
  output logic [BYTE_W-1:0] data_out3,
  output logic              valid_out0,
  output logic              valid_out1,
  output logic              valid_out2,
  output logic              valid_out3,
  output logic              full0,
  output logic              full1,
  output logic              full2,
  output logic              full3,
  output logic              empty0,
  output logic              empty1,
  output logic              empty2,
  output logic              empty3,
  output logic              almost_full0,
  output logic              almost_full1,
  output logic              almost_full2,
  output logic              almost_full3,
  output logic              err_ovf0,
  output logic              err_ovf1,
  output logic              err_ovf2,
  output logic              err_ovf3,
  output logic              err_udf0,
  output logic              err_udf1,
  output logic              err_udf2,
  output logic              err_udf3
);
  logic [BYTE_W-1:0] din [LANES];
  logic [BYTE_W-1:0] dout [LANES];
  logic vin [LANES];
  logic rd [LANES];
  logic vout [LANES];
  lane_flags_t flg [LANES];
  assign din = '{data_in0, data_in1, data_in2, data_in3};
  assign vin = '{valid_in0, valid_in1, valid_in2, valid_in3};
  assign rd = '{pop0, pop1, pop2, pop3};
  assign {data_out0, valid_out0, full0, empty0, almost_full0, err_ovf0, err_udf0} = {dout[0], vout[0], flg[0]};
  assign {data_out1, valid_out1, full1, empty1, almost_full1, err_ovf1, err_udf1} = {dout[1], vout[1], flg[1]};
  assign {data_out2, valid_out2, full2, empty2, almost_full2, err_ovf2, err_udf2} = {dout[2], vout[2], flg[2]};
  assign {data_out3, valid_out3, full3, empty3, almost_full3, err_ovf3, err_udf3} = {dout[3], vout[3], flg[3]};
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_fifo_8 #(.DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL)) u_fifo (
      .clk(clk),
      .reset_L(reset_L),
      .data_in(din[i]),
      .valid_in(vin[i]),
      .pop(rd[i]),
      .data_out(dout[i]),
      .valid_out(vout[i]),
      .flags(flg[i])
    );
  end
endmodule

// File: tb/tb_lane_fifo_bank_4x8.sv
// tb_lane_fifo_bank_4x8: directed stimulus with a per-lane expected-byte scoreboard drained by an output monitor
module tb_lane_fifo_bank_4x8;
`ifdef LANE_ERR_EN
  localparam logic EE = 1'b1;
`else
  localparam logic EE = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset_L = 1'b0;
  logic [7:0] din [4];
  logic vin [4];
  logic pop [4];
  logic [7:0] dout [4];
  logic vout [4], full [4], empty [4], af [4], eo [4], eu [4];
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];
  logic [7:0] q3 [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_fifo_bank_4x8 dut (
    .clk(clk), .reset_L(reset_L),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .valid_in0(vin[0]), .valid_in1(vin[1]), .valid_in2(vin[2]), .valid_in3(vin[3]),
    .pop0(pop[0]), .pop1(pop[1]), .pop2(pop[2]), .pop3(pop[3]),
    .data_out0(dout[0]), .data_out1(dout[1]), .data_out2(dout[2]), .data_out3(dout[3]),
    .valid_out0(vout[0]), .valid_out1(vout[1]), .valid_out2(vout[2]), .valid_out3(vout[3]),
    .full0(full[0]), .full1(full[1]), .full2(full[2]), .full3(full[3]),
    .empty0(empty[0]), .empty1(empty[1]), .empty2(empty[2]), .empty3(empty[3]),
    .almost_full0(af[0]), .almost_full1(af[1]), .almost_full2(af[2]), .almost_full3(af[3]),
    .err_ovf0(eo[0]), .err_ovf1(eo[1]), .err_ovf2(eo[2]), .err_ovf3(eo[3]),
    .err_udf0(eu[0]), .err_udf1(eu[1]), .err_udf2(eu[2]), .err_udf3(eu[3])
  );

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      vin[l] = 1'b0;
      pop[l] = 1'b0;
    end
  endtask

  task automatic push(int l, logic [7:0] d);
    vin[l] = 1'b1;
    din[l] = d;
    tick();
  endtask

  task automatic pop_exp(int l, logic [7:0] e);
    case (l)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
    pop[l] = 1'b1;
    tick();
  endtask

  task automatic pop_none(int l);
    pop[l] = 1'b1;
    tick();
  endtask

  // monitor: every presented byte must match the oldest expected byte of its lane
  always @(negedge clk) begin
    logic [7:0] e;
    logic has;
    if (reset_L)
      for (int l = 0; l < 4; l++)
        if (vout[l]) begin
          has = 1'b0;
          e = 8'h00;
          case (l)
            0: if (q0.size() > 0) begin has = 1'b1; e = q0.pop_front(); end
            1: if (q1.size() > 0) begin has = 1'b1; e = q1.pop_front(); end
            2: if (q2.size() > 0) begin has = 1'b1; e = q2.pop_front(); end
            default: if (q3.size() > 0) begin has = 1'b1; e = q3.pop_front(); end
          endcase
          checks++;
          if (!has) begin
            errors++;
            $display("FAIL out_lane%0d unexpected byte %0h", l, dout[l]);
          end else if (dout[l] !== e) begin
            errors++;
            $display("FAIL out_lane%0d got %0h exp %0h", l, dout[l], e);
          end
        end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    for (int l = 0; l < 4; l++) begin
      din[l] = 8'h00;
      vin[l] = 1'b0;
      pop[l] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int l = 0; l < 4; l++) begin
      chk($sformatf("rst_empty%0d", l), empty[l], 1);
      chk($sformatf("rst_full%0d", l), full[l], 0);
      chk($sformatf("rst_af%0d", l), af[l], 0);
      chk($sformatf("rst_dout%0d", l), dout[l], 0);
      chk($sformatf("rst_vout%0d", l), vout[l], 0);
      chk($sformatf("rst_err%0d", l), {eo[l], eu[l]}, 0);
    end
    reset_L = 1'b1;
    // reset mid-traffic on lane0
    push(0, 8'hA0);
    push(0, 8'hA1);
    push(0, 8'hA2);
    chk("mid_empty0", empty[0], 0);
    chk("mid_af0", af[0], 1);
    reset_L = 1'b0;
    #2;
    chk("mrst_empty0", empty[0], 1);
    chk("mrst_af0", af[0], 0);
    chk("mrst_dout0", dout[0], 0);
    chk("mrst_vout0", vout[0], 0);
    tick();
    reset_L = 1'b1;
    pop_none(0);
    chk("mrst_pop_vout0", vout[0], 0);
    chk("mrst_pop_empty0", empty[0], 1);
    // order and pointer wrap on lane2
    push(2, 8'hA1);
    push(2, 8'hA2);
    push(2, 8'hA3);
    push(2, 8'hA4);
    chk("wrap_full2_a", full[2], 1);
    pop_exp(2, 8'hA1);
    pop_exp(2, 8'hA2);
    chk("wrap_full2_mid", full[2], 0);
    push(2, 8'hA5);
    push(2, 8'hA6);
    chk("wrap_full2_b", full[2], 1);
    for (int k = 0; k < 4; k++) pop_exp(2, 8'hA3 + 8'(k));
    chk("wrap_empty2", empty[2], 1);
    // overflow on lane1
    for (int k = 0; k < 5; k++) push(1, 8'h10 + 8'(k));
    chk("ovf_full1", full[1], 1);
    chk("ovf_err1", eo[1], EE);
    for (int k = 0; k < 4; k++) pop_exp(1, 8'h10 + 8'(k));
    pop_none(1);
    chk("ovf_empty1", empty[1], 1);
    chk("ovf_udf1", eu[1], EE);
    // full lane3 with simultaneous push and pop
    for (int k = 0; k < 4; k++) push(3, 8'h30 + 8'(k));
    vin[3] = 1'b1;
    din[3] = 8'h55;
    pop_exp(3, 8'h30);
    chk("pp_full3", full[3], 1);
    chk("pp_ovf3", eo[3], 0);
    pop_exp(3, 8'h31);
    pop_exp(3, 8'h32);
    pop_exp(3, 8'h33);
    pop_exp(3, 8'h55);
    chk("pp_empty3", empty[3], 1);
    // underflow on lane0
    push(0, 8'h77);
    pop_exp(0, 8'h77);
    pop_none(0);
    chk("udf_vout0", vout[0], 0);
    chk("udf_dout0", dout[0], 8'h77);
    chk("udf_err0", eu[0], EE);
    // lane independence: round-robin demux stream, lane1 stalled
    for (int b = 8'h10; b < 8'h20; b++) begin
      push(b & 3, 8'(b));
      if (b == 8'h19) begin
        chk("ind_af1", af[1], 1);
        chk("ind_full1_early", full[1], 0);
      end
    end
    for (int k = 0; k < 4; k++) begin
      q0.push_back(8'h10 + 8'(4 * k));
      q2.push_back(8'h12 + 8'(4 * k));
      q3.push_back(8'h13 + 8'(4 * k));
      pop[0] = 1'b1;
      pop[2] = 1'b1;
      pop[3] = 1'b1;
      tick();
    end
    chk("ind_full1", full[1], 1);
    chk("ind_empty0", empty[0], 1);
    chk("ind_empty2", empty[2], 1);
    chk("ind_empty3", empty[3], 1);
    for (int k = 0; k < 4; k++) pop_exp(1, 8'h11 + 8'(4 * k));
    chk("ind_empty1", empty[1], 1);
    tick();
    tick();
    chk("left_q0", q0.size(), 0);
    chk("left_q1", q1.size(), 0);
    chk("left_q2", q2.size(), 0);
    chk("left_q3", q3.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
